rr_resource_arbiter: RTL

- Round-robin arbiter and sequencer that shares one multi-cycle datapath resource among N requesters.
- Built from the same primitive-cell datapath style as the rest of the lab designs.
- Detects any pending request, grants exactly one requester, issues a one-cycle start pulse to the resource, holds the grant until the resource reports done, then rotates priority.
- Sits between the requesting units and the shared datapath.

---
 rtl/rr_resource_arbiter_if.sv | 24 ++
 rtl/rr_resource_arbiter.sv | 161 ++++++++++++++++
 2 files changed

// File: rtl/rr_resource_arbiter_if.sv
// Request/grant bundle between the requesting units and the shared-resource arbiter.
// The slave modport is the arbiter side; the master modport is the requester/datapath side.
interface rr_resource_arbiter_if #(
    parameter int N  = 4,
    parameter int IW = (N > 1) ? $clog2(N) : 1
);
    logic [N-1:0]  req;
    logic          done;
    logic [N-1:0]  gnt;
    logic [IW-1:0] gnt_id;
    logic          start;
    logic          busy;
    logic          timeout;

    modport slave (
        input  req, done,
        output gnt, gnt_id, start, busy, timeout
    );

    modport master (
        output req, done,
        input  gnt, gnt_id, start, busy, timeout
    );
endinterface

// File: rtl/rr_resource_arbiter.sv
// Round-robin arbiter/sequencer sharing one multi-cycle resource among N requesters.
// Optional watchdog on the WAIT state is compiled in with `define RR_ARB_TIMEOUT_EN.
module rr_resource_arbiter #(
    parameter int N       = 4,
    parameter int IW      = (N > 1) ? $clog2(N) : 1,
    parameter int TIMEOUT = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    rr_resource_arbiter_if.slave bus
);
    typedef enum logic [1:0] {S_IDLE, S_START, S_WAIT} state_e;

    state_e        state_q, state_d;
    logic [N-1:0]  gnt_q, gnt_d;
    logic [IW-1:0] gnt_id_q, gnt_id_d;
    logic [IW-1:0] ptr_q, ptr_d;
    logic          timeout_q, timeout_d;
    logic          wd_expire;

    logic          any_req;
    logic [N-1:0]  rot;
    logic          sel_found;
    logic [IW-1:0] sel_off;
    logic [IW:0]   sel_sum;
    logic [IW-1:0] sel_id;
    logic [N-1:0]  sel_onehot;
    logic [IW:0]   inc_sum;
    logic [IW-1:0] ptr_inc;

    assign any_req = |bus.req;

    // Rotate so bit 0 is the requester at ptr; the first set bit is the offset from ptr.
    assign rot = N'({bus.req, bus.req} >> ptr_q);

    always_comb begin
        sel_found = 1'b0;
        sel_off   = '0;
        for (int i = 0; i < N; i++) begin
            if (!sel_found && rot[i]) begin
                sel_found = 1'b1;
                sel_off   = IW'(i);
            end
        end
    end

    always_comb begin
        sel_sum = {1'b0, ptr_q} + {1'b0, sel_off};
        if (sel_sum >= (IW+1)'(N)) begin
            sel_sum = sel_sum - (IW+1)'(N);
        end
        sel_id = IW'(sel_sum);
    end

    generate
        for (genvar gi = 0; gi < N; gi++) begin : g_onehot
            assign sel_onehot[gi] = (sel_id == IW'(gi));
        end
    endgenerate

    always_comb begin
        inc_sum = {1'b0, gnt_id_q} + (IW+1)'(1);
        if (inc_sum >= (IW+1)'(N)) begin
            inc_sum = '0;
        end
        ptr_inc = IW'(inc_sum);
    end

`ifdef RR_ARB_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT + 1);

    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (state_d == S_START) begin
            cnt_d = '0;
        end else if (state_q == S_WAIT) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign wd_expire = (state_q == S_WAIT) && (cnt_q == CW'(TIMEOUT - 1));
`else
    // Watchdog compiled out: WAIT holds until done; TIMEOUT has no effect.
    logic unused_timeout_param;
    assign unused_timeout_param = (TIMEOUT > 0);
    assign wd_expire = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            gnt_q     <= '0;
            gnt_id_q  <= '0;
            ptr_q     <= '0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            gnt_q     <= gnt_d;
            gnt_id_q  <= gnt_id_d;
            ptr_q     <= ptr_d;
            timeout_q <= timeout_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        gnt_d     = gnt_q;
        gnt_id_d  = gnt_id_q;
        ptr_d     = ptr_q;
        timeout_d = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (any_req) begin
                    state_d  = S_START;
                    gnt_d    = sel_onehot;
                    gnt_id_d = sel_id;
                end
            end
            S_START: begin
                if (bus.done) begin
                    state_d = S_IDLE;
                    gnt_d   = '0;
                    ptr_d   = ptr_inc;
                end else begin
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                // done wins over a simultaneous watchdog expiry
                if (bus.done || wd_expire) begin
                    state_d   = S_IDLE;
                    gnt_d     = '0;
                    ptr_d     = ptr_inc;
                    timeout_d = !bus.done;
                end
            end
            default: begin
                state_d = S_IDLE;
                gnt_d   = '0;
            end
        endcase
    end

    always_comb begin
        bus.gnt     = gnt_q;
        bus.gnt_id  = gnt_id_q;
        bus.start   = (state_q == S_START);
        bus.busy    = |gnt_q;
        bus.timeout = timeout_q;
    end
endmodule
